// File: rtl/ktr_bin_pkg.sv
// Shared types and helpers for the multi-mode CABAC binarizer.
//   mode_e      : binarization mode selected per request
//   state_e     : serial bin-emission FSM states
//   TR_EG_PREFIX_LIMIT : prefix cMax multiplier for the TR+EG(k+1) mode
//   clog2_ceil  : ceil(log2(x)), used to size fixed-length codes
package ktr_bin_pkg;

  typedef enum logic [1:0] {
    TR    = 2'd0,
    EGK   = 2'd1,
    FL    = 2'd2,
    TR_EG = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TR_PFX  = 3'd1,
    TR_SFX  = 3'd2,
    EG_PFX  = 3'd3,
    EG_SFX  = 3'd4,
    FL_BITS = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam int TR_EG_PREFIX_LIMIT = 4;

  // Smallest r with (1 << r) >= x; x = 0 or 1 gives 0.
  function automatic int clog2_ceil(input logic [31:0] x);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < {1'b0, x}) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ktr_egk_binarizer_if.sv
// Request/result bundle of the binarizer.
//   master : requester side (drives start/operands/ack)
//   slave  : binarizer side (drives ready/bins/length/done/err)
interface ktr_egk_binarizer_if #(
  parameter int VALUE_WIDTH = 16,
  parameter int BIN_WIDTH   = 32,
  parameter int K_WIDTH     = 3,
  parameter int LEN_WIDTH   = $clog2(BIN_WIDTH + 1)
);
  logic                   start_i;
  logic                   ready_o;
  logic [1:0]             mode_i;
  logic [VALUE_WIDTH-1:0] N_i;
  logic [K_WIDTH-1:0]     K_i;
  logic [VALUE_WIDTH-1:0] cMax_i;
  logic [BIN_WIDTH-1:0]   bin_o;
  logic [LEN_WIDTH-1:0]   bin_length_o;
  logic                   done_o;
  logic                   err_o;
  logic                   ack_i;

  modport master (
    output start_i, mode_i, N_i, K_i, cMax_i, ack_i,
    input  ready_o, bin_o, bin_length_o, done_o, err_o
  );

  modport slave (
    input  start_i, mode_i, N_i, K_i, cMax_i, ack_i,
    output ready_o, bin_o, bin_length_o, done_o, err_o
  );
endinterface

// File: rtl/bin_shift_acc.sv
// Bin-string accumulator: shifts one bin per push into the LSB so the first
// bin ends up at bit len_o-1. Pushes beyond BIN_WIDTH are dropped and flagged.
//   clear_i : empty the string and drop the overflow flag
//   push_i  : append bin_i
//   bin_o / len_o / ovf_o : current string, bin count, overflow seen
module bin_shift_acc #(
  parameter int BIN_WIDTH = 32,
  parameter int LEN_WIDTH = $clog2(BIN_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 bin_i,
  output logic [BIN_WIDTH-1:0] bin_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 ovf_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_o <= '0;
      len_o <= '0;
      ovf_o <= 1'b0;
    end else if (clear_i) begin
      bin_o <= '0;
      len_o <= '0;
      ovf_o <= 1'b0;
    end else if (push_i) begin
      if (len_o < LEN_WIDTH'(BIN_WIDTH)) begin
        bin_o <= {bin_o[BIN_WIDTH-2:0], bin_i};
        len_o <= len_o + LEN_WIDTH'(1);
      end else begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ktr_egk_binarizer.sv
// Multi-mode CABAC binarizer (TR, EGk, FL, TR+EG(k+1)), one bin per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request operands, start/ready, bin result, done/ack, err
// Operands are latched when start_i & ready_o; the FSM then walks prefix and
// suffix states, pushing bins into bin_shift_acc, and waits in DONE for ack.
module ktr_egk_binarizer
  import ktr_bin_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int BIN_WIDTH   = 32,
  parameter int K_WIDTH     = 3,
  parameter int LEN_WIDTH   = $clog2(BIN_WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  ktr_egk_binarizer_if.slave bus
);

  // One extra bit so EG subtraction / TR_EG offset never wraps.
  localparam int NW   = VALUE_WIDTH + 1;
  // Counter for k: EG order can grow up to NW past the initial K+1.
  localparam int KR_W = $clog2(NW + (1 << K_WIDTH) + 2);

  state_e          state, state_nx;
  logic [NW-1:0]   n_r, n_nx;       // working value
  logic [KR_W-1:0] k_r, k_nx;       // EG order / suffix bits remaining
  logic [NW-1:0]   ones_r, ones_nx; // TR prefix ones remaining
  logic            term_r, term_nx; // TR prefix terminating zero pending
  logic            eg_r, eg_nx;     // TR_EG: EG(k+1) suffix follows prefix
  logic            err_r, err_nx;   // clamp seen

  logic acc_clear, acc_push, acc_bin, acc_ovf;

  // Accept-time operand decode.
  mode_e           mode_in;
  logic [NW-1:0]   n_in, cmax_in, cmax_tre;
  logic [KR_W-1:0] k_in;
  logic            tr_clamp, tr_trunc, tr_sfx, tre_trunc;
  logic [NW-1:0]   tr_nc, tr_lim, tr_p, tr_ones, tre_p;
  logic [KR_W-1:0] fl_len;

  assign mode_in  = mode_e'(bus.mode_i);
  assign n_in     = {1'b0, bus.N_i};
  assign cmax_in  = {1'b0, bus.cMax_i};
  assign k_in     = KR_W'(bus.K_i);
  assign cmax_tre = NW'(TR_EG_PREFIX_LIMIT) << bus.K_i;

  assign tr_clamp  = n_in > cmax_in;
  assign tr_nc     = tr_clamp ? cmax_in : n_in;
  assign tr_lim    = cmax_in >> bus.K_i;
  assign tr_p      = tr_nc >> bus.K_i;
  assign tr_trunc  = tr_p >= tr_lim;
  assign tr_ones   = tr_trunc ? tr_lim : tr_p;
  assign tr_sfx    = (tr_nc < cmax_in) && (bus.K_i != '0);
  assign tre_trunc = n_in >= cmax_tre;
  assign tre_p     = n_in >> bus.K_i;
  assign fl_len    = KR_W'(clog2_ceil(32'(cmax_in) + 32'd1));

  // Emission helpers.
  logic [NW-1:0]   eg_pow, sfx_sh;
  logic [KR_W-1:0] k_idx;
  logic            eg_more, sfx_bit, pfx_last;

  assign eg_pow   = NW'(1) << k_r;
  assign eg_more  = (k_r < KR_W'(NW)) && (n_r >= eg_pow);
  assign k_idx    = k_r - KR_W'(1);
  assign sfx_sh   = n_r >> k_idx;
  assign sfx_bit  = sfx_sh[0];
  // This cycle's bin is the last prefix bin.
  assign pfx_last = (ones_r == '0) || ((ones_r == NW'(1)) && !term_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      n_r    <= '0;
      k_r    <= '0;
      ones_r <= '0;
      term_r <= 1'b0;
      eg_r   <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      n_r    <= n_nx;
      k_r    <= k_nx;
      ones_r <= ones_nx;
      term_r <= term_nx;
      eg_r   <= eg_nx;
      err_r  <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    n_nx      = n_r;
    k_nx      = k_r;
    ones_nx   = ones_r;
    term_nx   = term_r;
    eg_nx     = eg_r;
    err_nx    = err_r;
    acc_clear = 1'b0;
    acc_push  = 1'b0;
    acc_bin   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          acc_clear = 1'b1;
          err_nx    = 1'b0;
          eg_nx     = 1'b0;
          term_nx   = 1'b0;
          ones_nx   = '0;
          case (mode_in)
            TR: begin
              n_nx     = tr_nc;
              k_nx     = tr_sfx ? k_in : '0;
              ones_nx  = tr_ones;
              term_nx  = !tr_trunc;
              err_nx   = tr_clamp;
              state_nx = (tr_ones != '0 || !tr_trunc) ? TR_PFX :
                         (tr_sfx ? TR_SFX : DONE);
            end
            EGK: begin
              n_nx     = n_in;
              k_nx     = k_in;
              state_nx = EG_PFX;
            end
            FL: begin
              n_nx     = tr_nc;
              k_nx     = fl_len;
              err_nx   = tr_clamp;
              state_nx = (fl_len != '0) ? FL_BITS : DONE;
            end
            default: begin
              // Prefix is never empty here: either 4 ones or p ones + zero.
              ones_nx  = tre_trunc ? NW'(TR_EG_PREFIX_LIMIT) : tre_p;
              term_nx  = !tre_trunc;
              eg_nx    = tre_trunc;
              n_nx     = tre_trunc ? (n_in - cmax_tre) : n_in;
              k_nx     = tre_trunc ? (k_in + KR_W'(1)) : k_in;
              state_nx = TR_PFX;
            end
          endcase
        end
      end
      TR_PFX: begin
        acc_push = 1'b1;
        if (ones_r != '0) begin
          acc_bin = 1'b1;
          ones_nx = ones_r - NW'(1);
        end else begin
          term_nx = 1'b0;
        end
        if (pfx_last)
          state_nx = eg_r ? EG_PFX : ((k_r != '0) ? TR_SFX : DONE);
      end
      EG_PFX: begin
        acc_push = 1'b1;
        if (eg_more) begin
          acc_bin = 1'b1;
          n_nx    = n_r - eg_pow;
          k_nx    = k_r + KR_W'(1);
        end else begin
          state_nx = (k_r != '0) ? EG_SFX : DONE;
        end
      end
      TR_SFX, EG_SFX, FL_BITS: begin
        acc_push = 1'b1;
        acc_bin  = sfx_bit;
        k_nx     = k_idx;
        if (k_r == KR_W'(1)) state_nx = DONE;
      end
      DONE: begin
        if (bus.ack_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  bin_shift_acc #(
    .BIN_WIDTH(BIN_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(acc_clear),
    .push_i (acc_push),
    .bin_i  (acc_bin),
    .bin_o  (bus.bin_o),
    .len_o  (bus.bin_length_o),
    .ovf_o  (acc_ovf)
  );

  assign bus.ready_o = (state == IDLE);
  assign bus.done_o  = (state == DONE);
  assign bus.err_o   = err_r | acc_ovf;

endmodule
